// File: rtl/rgb_to_ycbcr_stage_pkg.sv
// Shared image-processing types and the fixed-point constants of the
// full-range BT.601 RGB -> YCbCr conversion.
package P_ImageProcessing;

    typedef enum logic [1:0] {
        MB_INTRA = 2'd0,
        MB_INTER = 2'd1,
        MB_SKIP  = 2'd2,
        MB_PCM   = 2'd3
    } teMacroBlockType;

    localparam int DATA_W = 8;
    localparam int COEF_W = 8;
    localparam int SUM_W  = 18;

    // Coefficients scaled by 256; negative values subtract in the sum stage.
    localparam int COEF_Y_R  = 77;
    localparam int COEF_Y_G  = 150;
    localparam int COEF_Y_B  = 29;
    localparam int COEF_CB_R = -43;
    localparam int COEF_CB_G = -85;
    localparam int COEF_CB_B = 128;
    localparam int COEF_CR_R = 128;
    localparam int COEF_CR_G = -107;
    localparam int COEF_CR_B = -21;

    localparam int CHROMA_OFFSET = 128;
    localparam int ROUND         = 128;

endpackage

// File: rtl/rgb_to_ycbcr_stage_if.sv
// Frame-transfer handshake carrying one 24-bit pixel plus macroblock markers.
interface rgb_to_ycbcr_stage_if;
    import P_ImageProcessing::*;

    logic                active;
    teMacroBlockType     mb_type;
    logic [23:0]         data;
    logic                mb_end;
    logic                ready;

    modport master (output active, mb_type, data, mb_end, input ready);
    modport slave  (input active, mb_type, data, mb_end, output ready);

endinterface

// File: rtl/rgb_to_ycbcr_stage_mac3.sv
// One output channel: three coefficient products, signed rounded sum,
// then shift/offset/clamp. All stages advance together on en.
module ycbcr_mac3
    import P_ImageProcessing::*;
#(
    parameter int C_R    = 77,
    parameter int C_G    = 150,
    parameter int C_B    = 29,
    parameter int OFFSET = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] r,
    input  logic [DATA_W-1:0] g,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic [COEF_W-1:0] MAG_R = COEF_W'(C_R < 0 ? -C_R : C_R);
    localparam logic [COEF_W-1:0] MAG_G = COEF_W'(C_G < 0 ? -C_G : C_G);
    localparam logic [COEF_W-1:0] MAG_B = COEF_W'(C_B < 0 ? -C_B : C_B);
    localparam logic NEG_R = (C_R < 0);
    localparam logic NEG_G = (C_G < 0);
    localparam logic NEG_B = (C_B < 0);

    localparam logic signed [SUM_W-1:0] ROUND_S  = SUM_W'(ROUND);
    localparam logic signed [SUM_W-1:0] OFFSET_S = SUM_W'(OFFSET);
    localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'((1 << DATA_W) - 1);

    logic [PROD_W-1:0]       prod_r_p0, prod_g_p0, prod_b_p0;
    logic signed [SUM_W-1:0] sum_p1;

    function automatic logic signed [SUM_W-1:0] signed_term(input logic [PROD_W-1:0] p,
                                                             input logic neg);
        logic signed [SUM_W-1:0] t;
        t = $signed(SUM_W'(p));
        return neg ? -t : t;
    endfunction

    function automatic logic signed [SUM_W-1:0] round_shift(input logic signed [SUM_W-1:0] s);
        return (s >>> DATA_W) + OFFSET_S;
    endfunction

    function automatic logic [DATA_W-1:0] saturate(input logic signed [SUM_W-1:0] s);
        if (s[SUM_W-1])
            return '0;
        else if (s > MAX_S)
            return '1;
        else
            return s[DATA_W-1:0];
    endfunction

    // S1: unsigned products against coefficient magnitudes
    always_ff @(posedge clk) begin
        if (en) begin
            prod_r_p0 <= r * MAG_R;
            prod_g_p0 <= g * MAG_G;
            prod_b_p0 <= b * MAG_B;
        end
    end

    // S2: signed sum with rounding constant
    always_ff @(posedge clk) begin
        if (en)
            sum_p1 <= signed_term(prod_r_p0, NEG_R) + signed_term(prod_g_p0, NEG_G)
                    + signed_term(prod_b_p0, NEG_B) + ROUND_S;
    end

    // S3: scale back, offset, clamp; this register drives the stage output
    always_ff @(posedge clk) begin
        if (rst)
            result <= '0;
        else if (en)
            result <= saturate(round_shift(sum_p1));
    end

endmodule

// File: rtl/rgb_to_ycbcr_stage.sv
// Stallable 3-stage RGB24 -> YCbCr converter with aligned macroblock markers
// and a per-macroblock pixel counter that flags malformed macroblocks.
module rgb_to_ycbcr_stage
    import P_ImageProcessing::*;
#(
    parameter int PIXELS_PER_MB = 64
) (
    input  logic                    ul1Clock,
    input  logic                    ul1Reset,
    rgb_to_ycbcr_stage_if.slave     upstream,
    rgb_to_ycbcr_stage_if.master    downstream,
    output logic                    ul1OutReset_n,
    output logic                    ul1MbError
);

    localparam int CNT_W = $clog2(PIXELS_PER_MB) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXELS_PER_MB - 1);

    logic              en, fire;
    logic              vld_p0, vld_p1, vld_p2;
    teMacroBlockType   type_p0, type_p1, type_p2;
    logic              end_p0, end_p1, end_p2;
    logic [DATA_W-1:0] y_p2, cb_p2, cr_p2;
    logic [CNT_W-1:0]  pix_cnt;

    // The whole pipeline advances unless the output holds a pixel nobody takes.
    assign en              = !vld_p2 | downstream.ready;
    assign upstream.ready  = en & !ul1Reset;
    assign fire            = upstream.active & upstream.ready;

    assign downstream.active  = vld_p2;
    assign downstream.mb_type = type_p2;
    assign downstream.mb_end  = end_p2;
    assign downstream.data    = {y_p2, cb_p2, cr_p2};

    ycbcr_mac3 #(.C_R(COEF_Y_R), .C_G(COEF_Y_G), .C_B(COEF_Y_B), .OFFSET(0)) y_mac (
        .clk(ul1Clock), .rst(ul1Reset), .en(en),
        .r(upstream.data[23:16]), .g(upstream.data[15:8]), .b(upstream.data[7:0]),
        .result(y_p2)
    );

    ycbcr_mac3 #(.C_R(COEF_CB_R), .C_G(COEF_CB_G), .C_B(COEF_CB_B), .OFFSET(CHROMA_OFFSET)) cb_mac (
        .clk(ul1Clock), .rst(ul1Reset), .en(en),
        .r(upstream.data[23:16]), .g(upstream.data[15:8]), .b(upstream.data[7:0]),
        .result(cb_p2)
    );

    ycbcr_mac3 #(.C_R(COEF_CR_R), .C_G(COEF_CR_G), .C_B(COEF_CR_B), .OFFSET(CHROMA_OFFSET)) cr_mac (
        .clk(ul1Clock), .rst(ul1Reset), .en(en),
        .r(upstream.data[23:16]), .g(upstream.data[15:8]), .b(upstream.data[7:0]),
        .result(cr_p2)
    );

    // S1..S3 control: valid shift register, flushed by reset
    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p0 <= fire;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge ul1Clock) begin
        if (en) begin
            type_p0 <= upstream.mb_type;
            end_p0  <= upstream.mb_end;
            type_p1 <= type_p0;
            end_p1  <= end_p0;
        end
    end

    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            type_p2 <= MB_INTRA;
            end_p2  <= 1'b0;
        end else if (en) begin
            type_p2 <= type_p1;
            end_p2  <= end_p1;
        end
    end

    always_ff @(posedge ul1Clock) begin
        ul1OutReset_n <= !ul1Reset;
    end

    // An End exactly on the last slot is the well-formed case.
    always_ff @(posedge ul1Clock) begin
        if (ul1Reset) begin
            pix_cnt    <= '0;
            ul1MbError <= 1'b0;
        end else if (fire) begin
            if (upstream.mb_end) begin
                if (pix_cnt != LAST)
                    ul1MbError <= 1'b1;
                pix_cnt <= '0;
            end else if (pix_cnt == LAST) begin
                ul1MbError <= 1'b1;
                pix_cnt    <= '0;
            end else begin
                pix_cnt <= pix_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rgb_to_ycbcr_stage.sv
// Bench for rgb_to_ycbcr_stage: vector table, macroblock/stall/error/reset
// sequences and a long randomized run, all checked through a scoreboard.
module tb_rgb_to_ycbcr_stage;
    import P_ImageProcessing::*;

    typedef struct {
        logic [23:0]     data;
        teMacroBlockType t;
        logic            e;
    } exp_t;

    typedef struct {
        logic [23:0] rgb;
        logic [23:0] ycc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic out_reset_n, mb_error;
    logic stop_rand;

    rgb_to_ycbcr_stage_if up_if ();
    rgb_to_ycbcr_stage_if dn_if ();

    rgb_to_ycbcr_stage #(.PIXELS_PER_MB(64)) dut (
        .ul1Clock      (clk),
        .ul1Reset      (rst),
        .upstream      (up_if),
        .downstream    (dn_if),
        .ul1OutReset_n (out_reset_n),
        .ul1MbError    (mb_error)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    int   out_seen = 0;
    int   end_seen = 0;
    exp_t sb[$];
    vec_t vecs[5];

    function automatic int sat8(input int v);
        return (v < 0) ? 0 : (v > 255) ? 255 : v;
    endfunction

    function automatic logic [23:0] model(input logic [23:0] rgb);
        int r, g, b, y, cb, cr;
        r  = int'(rgb[23:16]);
        g  = int'(rgb[15:8]);
        b  = int'(rgb[7:0]);
        y  = sat8((77 * r + 150 * g + 29 * b + 128) >>> 8);
        cb = sat8(((128 * b - 43 * r - 85 * g + 128) >>> 8) + 128);
        cr = sat8(((128 * r - 107 * g - 21 * b + 128) >>> 8) + 128);
        return {y[7:0], cb[7:0], cr[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Scoreboard: expected pixels queued at input transfer, compared at output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else begin
            if (up_if.active && up_if.ready)
                sb.push_back('{model(up_if.data), up_if.mb_type, up_if.mb_end});
            if (dn_if.active && dn_if.ready) begin
                out_seen++;
                if (dn_if.mb_end) end_seen++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_output", 32'(dn_if.data), 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", 32'(dn_if.data), 32'(e.data));
                    check("sb_type", 32'(dn_if.mb_type), 32'(e.t));
                    check("sb_end", 32'(dn_if.mb_end), 32'(e.e));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        up_if.active = 1'b0;
        up_if.mb_end = 1'b0;
        tick();
    endtask

    // Returns #1 after the edge on which the pixel was accepted.
    task automatic send(input logic [23:0] rgb, input teMacroBlockType t, input logic e);
        logic acc;
        up_if.active  = 1'b1;
        up_if.data    = rgb;
        up_if.mb_type = t;
        up_if.mb_end  = e;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = up_if.ready;
            @(posedge clk);
            #1;
            if (acc) return;
        end
        check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) tick();
        check("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        up_if.active = 1'b0;
        up_if.mb_end = 1'b0;
        tick();
        check("rst_active", 32'(dn_if.active), 32'd0);
        check("rst_data", 32'(dn_if.data), 32'd0);
        check("rst_end", 32'(dn_if.mb_end), 32'd0);
        check("rst_type", 32'(dn_if.mb_type), 32'(MB_INTRA));
        check("rst_mb_error", 32'(mb_error), 32'd0);
        check("rst_out_reset_n", 32'(out_reset_n), 32'd0);
        check("rst_in_ready", 32'(up_if.ready), 32'd0);
        rst = 1'b0;
        tick();
        check("rst_release_out_reset_n", 32'(out_reset_n), 32'd1);
    endtask

    task automatic send_mb(input int n, input int end_idx, input teMacroBlockType t);
        for (int i = 0; i < n; i++) send(24'($urandom), t, i == end_idx);
        idle();
    endtask

    initial begin
        int base, base_end;
        logic [23:0] snap;

        rst = 1'b1;
        stop_rand = 1'b0;
        up_if.active = 1'b0;
        up_if.data = '0;
        up_if.mb_type = MB_INTRA;
        up_if.mb_end = 1'b0;
        dn_if.ready = 1'b1;

        vecs[0] = '{24'hFF0000, 24'h4D55FF};
        vecs[1] = '{24'hFFFFFF, 24'hFF8080};
        vecs[2] = '{24'h000000, 24'h008080};
        vecs[3] = '{24'h00FF00, 24'h952B15};
        vecs[4] = '{24'h0000FF, 24'h1DFF6B};

        tick();
        do_reset();

        // Single pixels with a latency check: visible after two further edges.
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].rgb, MB_INTER, 1'b0);
            idle();
            check("lat_early_active", 32'(dn_if.active), 32'd0);
            tick();
            check("lat_active", 32'(dn_if.active), 32'd1);
            check("vec_data", 32'(dn_if.data), 32'(vecs[i].ycc));
            tick();
            tick();
        end
        drain();
        do_reset();

        // Clean back-to-back macroblock.
        base = out_seen;
        base_end = end_seen;
        send_mb(64, 63, MB_SKIP);
        drain();
        check("mb_out_count", 32'(out_seen - base), 32'd64);
        check("mb_end_count", 32'(end_seen - base_end), 32'd1);
        check("mb_error_clean", 32'(mb_error), 32'd0);

        // Downstream stall of 5 cycles mid-stream.
        base = out_seen;
        fork
            send_mb(64, 63, MB_INTER);
            begin
                repeat (8) tick();
                dn_if.ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    if (k == 0) snap = dn_if.data;
                    check("stall_active", 32'(dn_if.active), 32'd1);
                    check("stall_in_ready", 32'(up_if.ready), 32'd0);
                    check("stall_data_head", 32'(dn_if.data), 32'(sb.size() != 0 ? sb[0].data : 24'hXXXXXX));
                    if (k != 0) check("stall_data_frozen", 32'(dn_if.data), 32'(snap));
                    @(posedge clk);
                    #1;
                end
                dn_if.ready = 1'b1;
            end
        join
        drain();
        check("stall_out_count", 32'(out_seen - base), 32'd64);
        check("stall_mb_error", 32'(mb_error), 32'd0);

        // Short macroblock: End on pixel 10, error sticky across a clean one.
        base = out_seen;
        for (int i = 0; i < 11; i++) send(24'($urandom), MB_INTRA, i == 10);
        check("err_short_set", 32'(mb_error), 32'd1);
        idle();
        send_mb(64, 63, MB_INTRA);
        drain();
        check("err_short_sticky", 32'(mb_error), 32'd1);
        check("err_short_out_count", 32'(out_seen - base), 32'd75);

        // Long macroblock: 70 pixels, no End.
        do_reset();
        base = out_seen;
        for (int i = 0; i < 70; i++) begin
            send(24'($urandom), MB_PCM, 1'b0);
            if (i == 62) check("err_long_before", 32'(mb_error), 32'd0);
            if (i == 63) check("err_long_set", 32'(mb_error), 32'd1);
        end
        idle();
        drain();
        check("err_long_sticky", 32'(mb_error), 32'd1);
        check("err_long_out_count", 32'(out_seen - base), 32'd70);

        // Reset with pixels in flight.
        do_reset();
        for (int i = 0; i < 3; i++) send(24'($urandom), MB_INTER, 1'b0);
        rst = 1'b1;
        up_if.active = 1'b0;
        tick();
        check("flush_out_reset_n_low", 32'(out_reset_n), 32'd0);
        check("flush_active", 32'(dn_if.active), 32'd0);
        rst = 1'b0;
        tick();
        check("flush_out_reset_n_high", 32'(out_reset_n), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("flush_no_stale", 32'(dn_if.active), 32'd0);
            tick();
        end
        base = out_seen;
        send_mb(64, 63, MB_SKIP);
        drain();
        check("flush_clean_mb_error", 32'(mb_error), 32'd0);
        check("flush_clean_count", 32'(out_seen - base), 32'd64);

        // Randomized traffic with random bubbles and back-pressure.
        base = out_seen;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    if ($urandom_range(0, 4) == 0) idle();
                    send(24'($urandom), teMacroBlockType'($urandom_range(0, 3)), (n % 64) == 63);
                end
                idle();
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    dn_if.ready = ($urandom_range(0, 3) != 0);
                    tick();
                end
                dn_if.ready = 1'b1;
            end
        join
        drain();
        check("rand_out_count", 32'(out_seen - base), 32'd10000);
        check("rand_mb_error", 32'(mb_error), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rgb_to_ycbcr_stage.md
# rgb_to_ycbcr_stage

Streaming colour-space converter directly downstream of the frame-transfer source. It consumes the RGB24 macroblock pixel stream, converts every pixel to full-range YCbCr (JPEG/BT.601 coefficients) through a 3-stage stallable pipeline, and re-emits it on an identical frame-transfer handshake toward the encoder. Macroblock type and end markers travel aligned with their pixels. A per-macroblock pixel counter flags malformed macroblocks.

## Interface
- PIXELS_PER_MB, 64: pixels expected per macroblock (power of 2, 16..256)
- ul1Clock  in  1  common clock
- ul1Reset  in  1  synchronous, active-high reset
- ul1InActive  in  1  upstream pixel valid
- eInMacroBlockType  in  teMacroBlockType  type of incoming macroblock
- ul24InRgb24Data  in  24  {R[23:16], G[15:8], B[7:0]}
- ul1InMacroBlockEnd  in  1  last pixel of macroblock
- ul1InReady  out  1  stage accepts a pixel this cycle
- ul1OutReset_n  out  1  registered, active-low reset toward downstream, equal to !ul1Reset delayed 1 cycle
- ul1OutActive  out  1  output pixel valid
- eOutMacroBlockType  out  teMacroBlockType  aligned type
- ul24OutYCbCrData  out  24  {Y[23:16], Cb[15:8], Cr[7:0]}
- ul1OutMacroBlockEnd  out  1  aligned end marker
- ul1OutReady  in  1  downstream ready
- ul1MbError  out  1  sticky malformed-macroblock flag

## Operation
- Transfer on a port occurs in any cycle where Active and Ready are both high. Data are don't-care otherwise.
- Pipeline enable: en = !ul1OutActive | ul1OutReady. ul1InReady = en & !ul1Reset (combinational). When en is low, all stages hold.
- S1: nine 8x8 unsigned products, coefficients 77/150/29, 43/85/128, 128/107/21. Each stage carries valid, type and end.
- S2: signed 18-bit sums, each plus rounding constant 128:
  - Y = 77R + 150G + 29B
  - Cb = 128B − 43R − 85G
  - Cr = 128R − 107G − 21B
- S3: arithmetic shift right by 8, add 128 to Cb/Cr, clamp each channel to 0..255. The S3 register drives the outputs.
- Pixel counter: width log2(PIXELS_PER_MB)+1. Counts input transfers and returns to 0 on every transfer with ul1InMacroBlockEnd.
  - End arriving at a count other than PIXELS_PER_MB−1 sets ul1MbError.
  - Reaching PIXELS_PER_MB−1 without End also sets ul1MbError, and the counter wraps to 0.
- In both error cases the pixels still pass through unchanged. ul1MbError clears only on reset.
- Type is passed through verbatim and is not checked.

## Timing
- Latency: an input transfer in cycle N appears on the outputs in cycle N+3 when no stall occurs. Throughput is 1 pixel/cycle.
- Stall: while ul1OutActive=1 and ul1OutReady=0, the outputs hold stable and ul1InReady=0 in the same cycle. No pixel is lost or duplicated.
- Bubbles: invalid cycles propagate as ul1OutActive=0 and never block acceptance.
- Reset values (the cycle after ul1Reset is sampled high):
  - ul1OutActive=0, ul24OutYCbCrData=0, ul1OutMacroBlockEnd=0, eOutMacroBlockType = first enumerator.
  - ul1MbError=0, pixel counter=0, all stage valids=0, ul1OutReset_n=0.
- ul1InReady=0 combinationally while ul1Reset=1.
- Reset mid-macroblock flushes the pipeline and discards in-flight pixels. Counting restarts at 0 with no error raised.
- Simultaneous input End and error-count reach are the correct case: no error.

## Structure
- The P_ImageProcessing package holds teMacroBlockType (existing) and new localparams: the coefficients, CHROMA_OFFSET=128 and ROUND=128.
- One sub-module, ycbcr_mac3: a single-channel 3-stage multiply/sum/round-clamp slice with enable. It is instantiated three times with coefficient and offset parameters.
- The top level holds the valid/type/end shift registers, the enable, and the pixel counter.

## Test plan
- Reset then single pixels, ready held high:
  - 0xFF0000 gives 0x4D55FF 3 cycles later.
  - 0xFFFFFF gives 0xFF8080.
  - 0x000000 gives 0x008080.
- Back-to-back 64-pixel macroblock with End on pixel 63: 64 consecutive outputs with End only on the 64th, type echoed, ul1MbError=0.
- ul1OutReady low for 5 cycles mid-stream: outputs frozen, ul1InReady=0, and the output sequence is identical to the unstalled reference.
- End on pixel 10, and separately 70 pixels with no End: ul1MbError goes high and stays high, and all pixels are still emitted.
- ul1Reset pulsed with 3 pixels in flight: no stale output after release, ul1OutReset_n low for 1 cycle, and a following clean macroblock gives no error.
- Random RGB with random ready/active (10k pixels) against a golden model using the integer formula: bit-exact match, in order.
